pipe_freeze_ctrl: RTL and testbench

PIPE_FREEZE_CTRL -- requirements
Module: pipe_freeze_ctrl

---
 rtl/pipe_freeze_ctrl.sv | 93 +++++++++
 tb/tb_pipe_freeze_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_freeze_ctrl.sv
// Fetch/decode/execute pipeline register control with hazard freeze,
// bubble insertion into E, branch redirect with delay slot, and a saturating stall counter.
module pipe_freeze_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_taken_D,
    input  logic [31:0] npc_D,
    input  logic [31:0] instr_F,
    input  logic [31:0] rs_val_D,
    input  logic [31:0] rt_val_D,
    input  logic [31:0] ext_imm_D,
    output logic [31:0] pc_F,
    output logic [31:0] ir_D,
    output logic [31:0] pc4_D,
    output logic [31:0] ir_E,
    output logic [31:0] pc8_E,
    output logic [31:0] rs_val_E,
    output logic [31:0] rt_val_E,
    output logic [31:0] imm_E,
    output logic        valid_E,
    output logic [15:0] stall_cnt
);

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic [31:0] pc_plus4;
    logic [31:0] pc_next;

    // A branch still waiting on operands has no valid outcome, so stall wins.
    always_comb begin
        pc_plus4 = pc_F + 32'd4;
        pc_next  = pc_plus4;
        if (stall) begin
            pc_next = pc_F;
        end else if (br_taken_D) begin
            pc_next = npc_D;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_F <= RESET_PC;
        end else begin
            pc_F <= pc_next;
        end
    end

    // F/D is never flushed: the instruction after a branch is its delay slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir_D  <= '0;
            pc4_D <= '0;
        end else if (!stall) begin
            ir_D  <= instr_F;
            pc4_D <= pc_plus4;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir_E     <= '0;
            pc8_E    <= '0;
            rs_val_E <= '0;
            rt_val_E <= '0;
            imm_E    <= '0;
            valid_E  <= 1'b0;
        end else if (stall) begin
            ir_E     <= '0;
            pc8_E    <= '0;
            rs_val_E <= '0;
            rt_val_E <= '0;
            imm_E    <= '0;
            valid_E  <= 1'b0;
        end else begin
            ir_E     <= ir_D;
            pc8_E    <= pc4_D + 32'd4;
            rs_val_E <= rs_val_D;
            rt_val_E <= rt_val_D;
            imm_E    <= ext_imm_D;
            valid_E  <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipe_freeze_ctrl.sv
// Scoreboard bench for pipe_freeze_ctrl: a spec-level model pushes expected
// register contents per edge, popped and compared one edge later.
module tb_pipe_freeze_ctrl;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        br_taken_D;
    logic [31:0] npc_D;
    logic [31:0] instr_F;
    logic [31:0] rs_val_D;
    logic [31:0] rt_val_D;
    logic [31:0] ext_imm_D;
    logic [31:0] pc_F;
    logic [31:0] ir_D;
    logic [31:0] pc4_D;
    logic [31:0] ir_E;
    logic [31:0] pc8_E;
    logic [31:0] rs_val_E;
    logic [31:0] rt_val_E;
    logic [31:0] imm_E;
    logic        valid_E;
    logic [15:0] stall_cnt;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] irD;
        logic [31:0] pc4D;
        logic [31:0] irE;
        logic [31:0] pc8E;
        logic [31:0] rsE;
        logic [31:0] rtE;
        logic [31:0] immE;
        logic        vE;
        logic [15:0] cnt;
    } expected_t;

    expected_t scoreboard[$];
    expected_t model;

    int passCount  = 0;
    int totalCount = 0;

    pipe_freeze_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .br_taken_D (br_taken_D),
        .npc_D      (npc_D),
        .instr_F    (instr_F),
        .rs_val_D   (rs_val_D),
        .rt_val_D   (rt_val_D),
        .ext_imm_D  (ext_imm_D),
        .pc_F       (pc_F),
        .ir_D       (ir_D),
        .pc4_D      (pc4_D),
        .ir_E       (ir_E),
        .pc8_E      (pc8_E),
        .rs_val_E   (rs_val_E),
        .rt_val_E   (rt_val_E),
        .imm_E      (imm_E),
        .valid_E    (valid_E),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Fetched word is derived from the model's fetch address so that every slot is unique.
    function automatic logic [31:0] instrOf(input logic [31:0] pc);
        return {pc[15:0], ~pc[15:0]};
    endfunction

    task automatic checkField(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    endtask

    task automatic resetModel();
        model.pc   = 32'h0000_3000;
        model.irD  = '0;
        model.pc4D = '0;
        model.irE  = '0;
        model.pc8E = '0;
        model.rsE  = '0;
        model.rtE  = '0;
        model.immE = '0;
        model.vE   = 1'b0;
        model.cnt  = '0;
    endtask

    task automatic checkOutput();
        expected_t e;
        totalCount++;
        assert (scoreboard.size() != 0) passCount++;
        else $error("[TB] FAIL sb_empty observed=0 expected=entry");
        if (scoreboard.size() != 0) begin
            e = scoreboard.pop_front();
            checkField("pc_F",      pc_F,              e.pc);
            checkField("ir_D",      ir_D,              e.irD);
            checkField("pc4_D",     pc4_D,             e.pc4D);
            checkField("ir_E",      ir_E,              e.irE);
            checkField("pc8_E",     pc8_E,             e.pc8E);
            checkField("rs_val_E",  rs_val_E,          e.rsE);
            checkField("rt_val_E",  rt_val_E,          e.rtE);
            checkField("imm_E",     imm_E,             e.immE);
            checkField("valid_E",   {31'd0, valid_E},  {31'd0, e.vE});
            checkField("stall_cnt", {16'd0, stall_cnt}, {16'd0, e.cnt});
        end
    endtask

    // Drive one edge worth of inputs, advance the model, then compare just after the edge.
    task automatic applyStimulus(input logic s, input logic b, input logic [31:0] n);
        logic [31:0] rs, rt, imm, ins;
        rs  = $urandom;
        rt  = $urandom;
        imm = $urandom;
        ins = instrOf(model.pc);
        stall      = s;
        br_taken_D = b;
        npc_D      = n;
        instr_F    = ins;
        rs_val_D   = rs;
        rt_val_D   = rt;
        ext_imm_D  = imm;
        if (s) begin
            if (model.cnt != 16'hFFFF) model.cnt = model.cnt + 16'd1;
            model.irE  = '0;
            model.pc8E = '0;
            model.rsE  = '0;
            model.rtE  = '0;
            model.immE = '0;
            model.vE   = 1'b0;
        end else begin
            model.irE  = model.irD;
            model.pc8E = model.pc4D + 32'd4;
            model.rsE  = rs;
            model.rtE  = rt;
            model.immE = imm;
            model.vE   = 1'b1;
            model.irD  = ins;
            model.pc4D = model.pc + 32'd4;
            model.pc   = b ? n : model.pc + 32'd4;
        end
        scoreboard.push_back(model);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic checkResetValues(input string tag);
        checkField({tag, "_pc"},  pc_F,  32'h0000_3000);
        checkField({tag, "_irD"}, ir_D,  32'h0);
        checkField({tag, "_irE"}, ir_E,  32'h0);
        checkField({tag, "_rsE"}, rs_val_E, 32'h0);
        checkField({tag, "_vE"},  {31'd0, valid_E}, 32'h0);
        checkField({tag, "_cnt"}, {16'd0, stall_cnt}, 32'h0);
    endtask

    initial begin
        logic [31:0] heldIr;
        reset      = 1'b0;
        stall      = 1'b0;
        br_taken_D = 1'b0;
        npc_D      = '0;
        instr_F    = '0;
        rs_val_D   = '0;
        rt_val_D   = '0;
        ext_imm_D  = '0;
        resetModel();
        repeat (2) @(posedge clk);
        #1;
        checkResetValues("por");
        #2 reset = 1'b1;

        $display("[TB] straight-line flow");
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkField("sl_pc1", pc_F, 32'h0000_3004);
        checkField("sl_irD1", ir_D, instrOf(32'h0000_3000));
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkField("sl_pc2", pc_F, 32'h0000_3008);
        checkField("sl_vE2", {31'd0, valid_E}, 32'h1);
        checkField("sl_irE2", ir_E, instrOf(32'h0000_3000));
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkField("sl_pc3", pc_F, 32'h0000_300C);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkField("sl_pc4", pc_F, 32'h0000_3010);

        $display("[TB] async reset during stall");
        applyStimulus(1'b1, 1'b0, 32'h0);
        #3 reset = 1'b0;
        #2;
        checkResetValues("ar");
        resetModel();
        #1 reset = 1'b1;

        $display("[TB] single stall and taken branch");
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkField("rs_pc1", pc_F, 32'h0000_3004);
        checkField("rs_irD1", ir_D, instrOf(32'h0000_3000));
        applyStimulus(1'b0, 1'b0, 32'h0);
        heldIr = ir_D;
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkField("st_pc", pc_F, 32'h0000_3008);
        checkField("st_irD", ir_D, instrOf(32'h0000_3004));
        checkField("st_cnt", {16'd0, stall_cnt}, 32'h1);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkField("st_resume_irE", ir_E, instrOf(32'h0000_3004));
        checkField("st_resume_pc", pc_F, 32'h0000_300C);
        applyStimulus(1'b0, 1'b1, 32'h0000_3100);
        checkField("br_pc", pc_F, 32'h0000_3100);
        checkField("br_slot", ir_D, instrOf(32'h0000_300C));
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkField("br_after", pc_F, 32'h0000_3104);

        $display("[TB] stall together with branch");
        applyStimulus(1'b1, 1'b1, 32'h0000_3100);
        checkField("sb_pc1", pc_F, 32'h0000_3104);
        applyStimulus(1'b1, 1'b1, 32'h0000_3100);
        checkField("sb_pc2", pc_F, 32'h0000_3104);
        checkField("sb_cnt", {16'd0, stall_cnt}, 32'h3);
        applyStimulus(1'b0, 1'b1, 32'h0000_3100);
        checkField("sb_pc3", pc_F, 32'h0000_3100);

        $display("[TB] stall counter saturation");
        for (int i = 0; i < 65540; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0);
        end
        checkField("sat_cnt", {16'd0, stall_cnt}, 32'h0000_FFFF);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkField("sat_hold", {16'd0, stall_cnt}, 32'h0000_FFFF);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkField("sat_resume_pc", pc_F, 32'h0000_3104);

        totalCount++;
        assert (scoreboard.size() == 0) passCount++;
        else $error("[TB] FAIL sb_leftover observed=%0d expected=0", scoreboard.size());

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
